// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester handshake and the tx_uart control signals of the
//   UART transmit arbiter.
//   Parameters:
//     NUM_REQ  number of requesters
//     ID_W     width of grant_id
//   Signals:
//     req_valid[NUM_REQ]    requester i has a byte on req_data[8i+7:8i]
//     req_data[8*NUM_REQ]   packed byte per requester
//     req_last[NUM_REQ]     byte of requester i closes its frame
//     req_ready[NUM_REQ]    1-cycle pulse: byte of requester i accepted
//     tx_start              1-cycle start pulse to tx_uart
//     tx_data[8]            byte to tx_uart, valid while tx_start=1
//     tx_busy               busy flag from tx_uart
//     grant_id[ID_W]        current or last owner
//     frame_active          owner holds the UART
//     frame_abort           1-cycle pulse when a stalled frame is aborted
//   Modports:
//     master  requester/tx_uart side (drives req_*, tx_busy)
//     slave   arbiter side
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [ID_W-1:0]      grant_id;
  logic                 frame_active;
  logic                 frame_abort;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, frame_active, frame_abort
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data, grant_id, frame_active, frame_abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one tx_uart serializer between NUM_REQ framed byte-stream
//   requesters. Grants are round-robin and locked for a whole frame: the
//   owner keeps the UART until its byte flagged last has been transmitted
//   (tx_busy seen high, then low). All outputs are registered.
//
//   Parameters:
//     NUM_REQ        number of requesters (2..8)
//     ID_W           width of grant_id, >= clog2(NUM_REQ)
//     TIMEOUT_CYCLES max cycles the owner may stall mid-frame (timeout build)
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    uart_tx_arbiter_if.slave (requester handshake + tx_uart control)
//
//   Build option:
//     `define UART_ARB_TIMEOUT_EN  enables the mid-frame stall timeout; an
//     expired stall pulses frame_abort and frees the UART. Without it the
//     arbiter waits indefinitely and frame_abort is tied low.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ID_W           = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_HI, WAIT_LO, NEXT} state_t;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]    grant_id_reg, grant_id_next;
  logic [NUM_REQ-1:0] req_ready_reg, req_ready_next;
  logic               tx_start_reg, tx_start_next;
  logic [7:0]         tx_data_reg, tx_data_next;
  logic               frame_active_reg, frame_active_next;
  logic               last_reg, last_next;

  // Owner selection as a one-hot mask, so the owner's byte/valid/last are
  // picked with AND-OR muxing instead of a variable index.
  logic [NUM_REQ-1:0] owner_sel;
  logic [7:0]         owner_byte_masked [NUM_REQ];
  logic [7:0]         owner_byte;
  logic               owner_valid;
  logic               owner_last;

  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;
  logic               frame_abort_reg, frame_abort_next;
`else
  // The stall limit has no effect when the timeout is not built in.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner
      assign owner_sel[gi]         = (grant_id_reg == ID_W'(gi));
      assign owner_byte_masked[gi] = bus.req_data[8*gi +: 8] & {8{owner_sel[gi]}};
    end
  endgenerate

  always_comb begin
    owner_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_byte = owner_byte | owner_byte_masked[i];
    end
  end

  assign owner_valid = |(bus.req_valid & owner_sel);
  assign owner_last  = |(bus.req_last & owner_sel);

  // Round-robin pick: scan distances 1..NUM_REQ from rr_ptr, the first valid
  // requester wins. rr_ptr itself is visited last, giving it lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pick_found && bus.req_valid[i] &&
            (((int'(rr_ptr_reg) + k) % NUM_REQ) == i)) begin
          pick_found = 1'b1;
          pick_idx   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    rr_ptr_next       = rr_ptr_reg;
    grant_id_next     = grant_id_reg;
    req_ready_next    = '0;
    tx_start_next     = 1'b0;
    tx_data_next      = tx_data_reg;
    frame_active_next = frame_active_reg;
    last_next         = last_reg;
`ifdef UART_ARB_TIMEOUT_EN
    frame_abort_next  = 1'b0;
    stall_cnt_next    = '0;
`endif
    case (state_reg)
      IDLE: begin
        // A UART still busy from before is never double-started.
        if (pick_found && !bus.tx_busy) begin
          grant_id_next     = pick_idx;
          rr_ptr_next       = pick_idx;
          frame_active_next = 1'b1;
          state_next        = LOAD;
        end
      end
      LOAD: begin
        tx_start_next  = 1'b1;
        tx_data_next   = owner_byte;
        req_ready_next = owner_sel;
        last_next      = owner_last;
        state_next     = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (last_reg) begin
            frame_active_next = 1'b0;
            state_next        = IDLE;
          end else begin
            state_next = NEXT;
          end
        end
      end
      NEXT: begin
        // Locked: only the owner can continue; everyone else waits.
        if (owner_valid) begin
          state_next = LOAD;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (stall_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // rr_ptr keeps the aborted owner so it ranks last next time.
          frame_abort_next  = 1'b1;
          frame_active_next = 1'b0;
          state_next        = IDLE;
        end else begin
          stall_cnt_next = stall_cnt_reg + 1'b1;
        end
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      rr_ptr_reg       <= ID_W'(NUM_REQ - 1);
      grant_id_reg     <= '0;
      req_ready_reg    <= '0;
      tx_start_reg     <= 1'b0;
      tx_data_reg      <= 8'h00;
      frame_active_reg <= 1'b0;
      last_reg         <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      frame_abort_reg  <= 1'b0;
      stall_cnt_reg    <= '0;
`endif
    end else begin
      state_reg        <= state_next;
      rr_ptr_reg       <= rr_ptr_next;
      grant_id_reg     <= grant_id_next;
      req_ready_reg    <= req_ready_next;
      tx_start_reg     <= tx_start_next;
      tx_data_reg      <= tx_data_next;
      frame_active_reg <= frame_active_next;
      last_reg         <= last_next;
`ifdef UART_ARB_TIMEOUT_EN
      frame_abort_reg  <= frame_abort_next;
      stall_cnt_reg    <= stall_cnt_next;
`endif
    end
  end

  assign bus.req_ready    = req_ready_reg;
  assign bus.tx_start     = tx_start_reg;
  assign bus.tx_data      = tx_data_reg;
  assign bus.grant_id     = grant_id_reg;
  assign bus.frame_active = frame_active_reg;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.frame_abort  = frame_abort_reg;
`else
  assign bus.frame_abort  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter. Two requesters are modelled from a
//   queue of (requester, delay, byte, last) items; tx_busy follows a simple
//   tx_uart model (rises 1 cycle after tx_start, stays high 10 cycles).
//   Outputs are sampled and inputs driven on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  localparam int NUM_REQ        = 2;
  localparam int ID_W           = 1;
  localparam int TIMEOUT_CYCLES = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  typedef struct { int req; int delay; logic [7:0] data; logic last; } item_t;
  typedef struct { int id; logic [7:0] data; int t; } start_t;

  item_t  q[$];
  start_t starts[$];
  int checks = 0;
  int errors = 0;
  int tcount = 0;
  int gap [NUM_REQ];
  int valid_tick [NUM_REQ];
  int busy_cnt = 0;
  bit start_pend = 0;
  bit busy_force = 0;
  bit fa_prev = 0;
  int fall_tick = -1;
  int abort_tick = -1;
  int abort_count = 0;
  int s1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input int d, input logic [7:0] data, input logic last);
    item_t it;
    it.req = r; it.delay = d; it.data = data; it.last = last;
    q.push_back(it);
  endtask

  function automatic int front(input int r);
    for (int k = 0; k < q.size(); k++) begin
      if (q[k].req == r) return k;
    end
    return -1;
  endfunction

  task automatic tick();
    int f;
    start_t s;
    @(negedge clk);
    tcount++;
    if (bus.tx_start) begin
      s.id = int'(bus.grant_id); s.data = bus.tx_data; s.t = tcount;
      starts.push_back(s);
      $display("t=%0d tx_start id=%0d data=%02h", tcount, s.id, s.data);
      if (bus.req_ready == '0) check("start_without_ready", 32'd0, 32'd1);
    end
    if (fa_prev && !bus.frame_active) fall_tick = tcount;
    fa_prev = bus.frame_active;
    if (bus.frame_abort) begin
      abort_tick = tcount;
      abort_count++;
      $display("t=%0d frame_abort", tcount);
    end
    if (busy_cnt > 0) busy_cnt--;
    if (start_pend) begin busy_cnt = 10; start_pend = 0; end
    if (bus.tx_start) start_pend = 1;
    bus.tx_busy = (busy_cnt > 0) || busy_force;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_ready[i]) begin
        f = front(i);
        check("ready_data", bus.tx_data, (f >= 0) ? q[f].data : 8'hxx);
        check("ready_with_start", bus.tx_start, 1);
        if (f >= 0) q.delete(f);
        bus.req_valid[i] = 1'b0;
        f = front(i);
        gap[i] = (f >= 0) ? q[f].delay : 0;
      end
      if (!bus.req_valid[i]) begin
        f = front(i);
        if (f >= 0) begin
          if (gap[i] > 0) gap[i]--;
          else begin
            bus.req_valid[i]         = 1'b1;
            bus.req_data[8*i +: 8]   = q[f].data;
            bus.req_last[i]          = q[f].last;
            valid_tick[i]            = tcount;
          end
        end
      end
    end
  endtask

  task automatic wait_starts(input int n, input string tag);
    int b = 0;
    while (starts.size() < n && b < 400) begin tick(); b++; end
    if (starts.size() < n) check(tag, starts.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int b = 0;
    while ((bus.frame_active || bus.tx_busy || q.size() != 0 || start_pend) && b < 400) begin
      tick(); b++;
    end
    if (bus.frame_active) check(tag, bus.frame_active, 0);
    tick(); tick();
  endtask

  task automatic check_start(input int k, input int id, input logic [7:0] data, input string tag);
    if (k < starts.size()) begin
      check({tag, "_id"}, starts[k].id, id);
      check({tag, "_data"}, starts[k].data, data);
    end else begin
      check({tag, "_missing"}, starts.size(), k + 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, bus.tx_start, 0);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_tx_data"}, bus.tx_data, 8'h00);
    check({tag, "_grant_id"}, bus.grant_id, 0);
    check({tag, "_frame_active"}, bus.frame_active, 0);
    check({tag, "_frame_abort"}, bus.frame_abort, 0);
  endtask

  task automatic flush_model();
    q.delete();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    busy_cnt = 0; start_pend = 0; bus.tx_busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) gap[i] = 0;
  endtask

  initial begin
    reset = 1'b1;
    flush_model();
    for (int i = 0; i < NUM_REQ; i++) valid_tick[i] = 0;

    // Reset state
    tick(); tick(); tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Single frame: req0 sends A5 with last
    starts.delete();
    push(0, 0, 8'hA5, 1'b1);
    wait_starts(1, "single_timeout");
    wait_idle("single_idle");
    check_start(0, 0, 8'hA5, "single");
    check("single_count", starts.size(), 1);
    check("single_latency", starts[0].t - valid_tick[0], 2);
    check("single_fa_fall", fall_tick - starts[0].t, 12);
    check("single_grant_id", bus.grant_id, 0);

    // Contention straight after reset: req0 {11,22 last}, req1 {33 last}
    reset = 1'b1;
    tick();
    reset = 1'b0;
    starts.delete();
    push(0, 0, 8'h11, 1'b0);
    push(0, 0, 8'h22, 1'b1);
    push(1, 0, 8'h33, 1'b1);
    wait_starts(3, "contention_timeout");
    wait_idle("contention_idle");
    check_start(0, 0, 8'h11, "contention0");
    check_start(1, 0, 8'h22, "contention1");
    check_start(2, 1, 8'h33, "contention2");

    // Fairness: both stream one-byte frames; last owner was req1
    starts.delete();
    for (int k = 0; k < 4; k++) begin
      push(0, 0, 8'h40 + 8'(k), 1'b1);
      push(1, 0, 8'h50 + 8'(k), 1'b1);
    end
    wait_starts(8, "fair_timeout");
    wait_idle("fair_idle");
    for (int k = 0; k < 8; k++) begin
      check_start(k, k % 2, ((k % 2) != 0) ? (8'h50 + 8'(k / 2)) : (8'h40 + 8'(k / 2)), "fair");
    end

    // Stall: req0 01 (not last), gap, 02 last; req1 77 waits throughout
    starts.delete();
`ifdef UART_ARB_TIMEOUT_EN
    push(0, 0, 8'h01, 1'b0);
    push(0, 15, 8'h02, 1'b1);
`else
    push(0, 0, 8'h01, 1'b0);
    push(0, 50, 8'h02, 1'b1);
`endif
    push(1, 0, 8'h77, 1'b1);
    wait_starts(3, "stall_timeout");
    wait_idle("stall_idle");
    check_start(0, 0, 8'h01, "stall0");
    check_start(1, 0, 8'h02, "stall1");
    check_start(2, 1, 8'h77, "stall2");
`ifdef UART_ARB_TIMEOUT_EN
    check("stall_gap", starts[1].t - starts[0].t, 17);
`else
    check("stall_gap", starts[1].t - starts[0].t, 52);
`endif

    // Reset in WAIT_LO of the first byte of a 3-byte frame from req0
    starts.delete();
    push(0, 0, 8'hA1, 1'b0);
    push(0, 0, 8'hA2, 1'b0);
    push(0, 0, 8'hA3, 1'b1);
    wait_starts(1, "midreset_timeout");
    s1 = starts[0].t;
    while (tcount < s1 + 5) tick();
    reset = 1'b1;
    flush_model();
    tick();
    check_reset_outputs("midreset");
    reset = 1'b0;
    tick();
    starts.delete();
    push(0, 0, 8'hC0, 1'b1);
    push(1, 0, 8'hC1, 1'b1);
    wait_starts(2, "postreset_timeout");
    wait_idle("postreset_idle");
    check_start(0, 0, 8'hC0, "postreset0");
    check_start(1, 1, 8'hC1, "postreset1");

    // tx_busy already high in IDLE: no grant until it drops
    starts.delete();
    busy_force = 1'b1;
    tick();
    push(0, 0, 8'hD0, 1'b1);
    for (int k = 0; k < 10; k++) tick();
    check("busy_idle_no_start", starts.size(), 0);
    check("busy_idle_no_frame", bus.frame_active, 0);
    busy_force = 1'b0;
    wait_starts(1, "busy_release_timeout");
    wait_idle("busy_release_idle");
    check_start(0, 0, 8'hD0, "busy_release");

`ifdef UART_ARB_TIMEOUT_EN
    // Timeout: last owner req0, so req1 wins first and then stalls
    starts.delete();
    push(1, 0, 8'hE0, 1'b0);
    push(1, 1000, 8'hE1, 1'b1);
    push(0, 0, 8'hE2, 1'b1);
    wait_starts(1, "timeout_first");
    begin : wait_abort
      int b = 0;
      while (abort_count == 0 && b < 200) begin tick(); b++; end
    end
    check("timeout_abort_seen", abort_count, 1);
    check("timeout_abort_time", abort_tick - starts[0].t, 32);
    check("timeout_frame_drop", bus.frame_active, 0);
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].req == 1) q.delete(k);
    end
    gap[1] = 0;
    wait_starts(2, "timeout_next");
    wait_idle("timeout_idle");
    check_start(0, 1, 8'hE0, "timeout0");
    check_start(1, 0, 8'hE2, "timeout1");
`else
    check("no_abort_ever", abort_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
